// File: rtl/resp_arbiter_pkg.sv
// Shared state encodings and defaults for the authentication-responder arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef MSG_LEN
`define MSG_LEN 32
`endif

// Counter width able to hold 0..t inclusive.
`ifndef RESP_ARB_CNT_W
`define RESP_ARB_CNT_W(t) ($clog2((t) + 1))
`endif

package resp_arbiter_pkg;

    // One-hot encodings keep each state decode to a single flop bit.
    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_WAIT    = 5'b00010,
        S_DELIVER = 5'b00100,
        S_RELEASE = 5'b01000,
        S_RECOVER = 5'b10000
    } state_t;

    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_RST_CYCLES     = 4;

endpackage

// File: rtl/resp_rr_pick.sv
// Round-robin requester select: first set bit strictly after 'last', wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller samples the result only when it can accept a new owner.
//
// Ports:
//   req  - request level per requester
//   last - index of the previous owner
//   gnt  - one-hot winner (0 when no request)
//   idx  - binary index of the winner
//   any  - at least one request present
module resp_rr_pick
    import resp_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Upper pass: indices above the previous owner get first chance.
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j] && (IDX_W'(j) > last)) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
        // Wrap-around pass: anything at or below the previous owner.
        for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/resp_arbiter.sv
// Shares one authentication responder between N_REQ requesters; optional macro RESP_ARB_FIXED_PRIO_EN.
// Latency: resp_req_in 1 cycle after a request is sampled; rsp_valid 1 cycle after resp_req_out is sampled.
// Backpressure: requesters hold req_in until rsp_valid; responder is held via Ack_in, bounded by TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   req_in, msg_in     - per-requester request level and message slice [i*MSG_W +: MSG_W]
//   grant              - one-hot current owner (0 when idle)
//   rsp_valid          - one-cycle response strobe per requester
//   rsp_timeout        - qualifies rsp_valid: transaction timed out
//   rsp_msg            - response message, valid with rsp_valid
//   busy               - state is not IDLE
//   resp_req_in        - to responder: request present
//   auth_msg_resp_in   - to responder: latched request message
//   Ack_in             - to responder: response consumed
//   resp_rst           - to responder: active-high reset pulse after a timeout
//   resp_req_out       - from responder: response ready
//   auth_msg_resp_out  - from responder: response message
//
// Define RESP_ARB_FIXED_PRIO_EN for lowest-index-wins selection without a pointer.
module resp_arbiter
    import resp_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int MSG_W          = `MSG_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RST_CYCLES     = DEF_RST_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*MSG_W-1:0] msg_in,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [N_REQ-1:0]       rsp_timeout,
    output logic [MSG_W-1:0]       rsp_msg,
    output logic                   busy,
    output logic                   resp_req_in,
    output logic [MSG_W-1:0]       auth_msg_resp_in,
    output logic                   Ack_in,
    output logic                   resp_rst,
    input  logic                   resp_req_out,
    input  logic [MSG_W-1:0]       auth_msg_resp_out
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // One counter serves both the response timeout and the reset pulse length.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int CNT_W   = `RESP_ARB_CNT_W(CNT_MAX);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;

    logic [N_REQ-1:0] nxt_grant, nxt_rsp_valid, nxt_rsp_timeout;
    logic [MSG_W-1:0] nxt_rsp_msg, nxt_auth_msg;
    logic             nxt_busy, nxt_resp_req_in, nxt_ack, nxt_resp_rst;

    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;

`ifdef RESP_ARB_FIXED_PRIO_EN
    // Lowest index wins; no fairness state is kept.
    always_comb begin
        pick_gnt = '0;
        pick_any = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!pick_any && req_in[j]) begin
                pick_any    = 1'b1;
                pick_gnt[j] = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] last, nxt_last;
    logic [IDX_W-1:0] g_idx, nxt_g_idx;
    logic [IDX_W-1:0] pick_idx;

    resp_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_in),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );
`endif

    always_comb begin
        nxt_state       = state;
        nxt_cnt         = cnt;
        nxt_grant       = grant;
        nxt_rsp_valid   = '0;
        nxt_rsp_timeout = '0;
        nxt_rsp_msg     = rsp_msg;
        nxt_auth_msg    = auth_msg_resp_in;
        nxt_resp_req_in = resp_req_in;
        nxt_ack         = Ack_in;
        nxt_resp_rst    = resp_rst;
`ifndef RESP_ARB_FIXED_PRIO_EN
        nxt_last        = last;
        nxt_g_idx       = g_idx;
`endif

        unique case (state)
            S_IDLE: begin
                if (pick_any) begin
                    nxt_grant = pick_gnt;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_gnt[i]) begin
                            nxt_auth_msg = msg_in[i*MSG_W +: MSG_W];
                        end
                    end
                    nxt_resp_req_in = 1'b1;
                    nxt_cnt         = '0;
                    nxt_state       = S_WAIT;
`ifndef RESP_ARB_FIXED_PRIO_EN
                    nxt_g_idx       = pick_idx;
`endif
                end
            end

            S_WAIT: begin
                nxt_cnt = cnt + 1'b1;
                // A response arriving on the last allowed cycle still wins.
                if (resp_req_out) begin
                    nxt_rsp_msg     = auth_msg_resp_out;
                    nxt_rsp_valid   = grant;
                    nxt_ack         = 1'b1;
                    nxt_resp_req_in = 1'b0;
                    nxt_state       = S_DELIVER;
                end else if (cnt == TO_LAST) begin
                    nxt_rsp_valid   = grant;
                    nxt_rsp_timeout = grant;
                    nxt_rsp_msg     = '0;
                    nxt_resp_req_in = 1'b0;
                    nxt_ack         = 1'b0;
                    nxt_resp_rst    = 1'b1;
                    nxt_cnt         = '0;
                    nxt_state       = S_RECOVER;
                end
            end

            S_DELIVER: begin
                nxt_cnt   = '0;
                nxt_state = S_RELEASE;
            end

            S_RELEASE: begin
                if (!resp_req_out) begin
                    nxt_ack   = 1'b0;
                    nxt_grant = '0;
                    nxt_state = S_IDLE;
`ifndef RESP_ARB_FIXED_PRIO_EN
                    nxt_last  = g_idx;
`endif
                end else if (cnt == TO_LAST) begin
                    // Responder never dropped its ready; the response was
                    // already delivered, so only the reset pulse follows.
                    nxt_ack      = 1'b0;
                    nxt_resp_rst = 1'b1;
                    nxt_cnt      = '0;
                    nxt_state    = S_RECOVER;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end

            S_RECOVER: begin
                nxt_resp_req_in = 1'b0;
                nxt_ack         = 1'b0;
                if (cnt == RST_LAST) begin
                    nxt_resp_rst = 1'b0;
                    nxt_grant    = '0;
                    nxt_cnt      = '0;
                    nxt_state    = S_IDLE;
`ifndef RESP_ARB_FIXED_PRIO_EN
                    nxt_last     = g_idx;
`endif
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end

            default: begin
                nxt_state       = S_IDLE;
                nxt_cnt         = '0;
                nxt_grant       = '0;
                nxt_resp_req_in = 1'b0;
                nxt_ack         = 1'b0;
                nxt_resp_rst    = 1'b0;
            end
        endcase

        nxt_busy = (nxt_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            grant            <= '0;
            rsp_valid        <= '0;
            rsp_timeout      <= '0;
            rsp_msg          <= '0;
            busy             <= 1'b0;
            resp_req_in      <= 1'b0;
            auth_msg_resp_in <= '0;
            Ack_in           <= 1'b0;
            resp_rst         <= 1'b0;
`ifndef RESP_ARB_FIXED_PRIO_EN
            // Pointer at the top index so requester 0 is first after reset.
            last             <= IDX_W'(N_REQ - 1);
            g_idx            <= '0;
`endif
        end else begin
            state            <= nxt_state;
            cnt              <= nxt_cnt;
            grant            <= nxt_grant;
            rsp_valid        <= nxt_rsp_valid;
            rsp_timeout      <= nxt_rsp_timeout;
            rsp_msg          <= nxt_rsp_msg;
            busy             <= nxt_busy;
            resp_req_in      <= nxt_resp_req_in;
            auth_msg_resp_in <= nxt_auth_msg;
            Ack_in           <= nxt_ack;
            resp_rst         <= nxt_resp_rst;
`ifndef RESP_ARB_FIXED_PRIO_EN
            last             <= nxt_last;
            g_idx            <= nxt_g_idx;
`endif
        end
    end

endmodule
